// File: rtl/ksa_pkg.sv
// Shared definitions for the Kogge-Stone adder slice: default operand width
// and the {generate, propagate} pair carried between prefix-tree stages.
package ksa_pkg;

  localparam int KSA_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic g;
    logic p;
  } ksa_gp_t;

  // Prefix-tree combine operator: (g_hi,p_hi) o (g_lo,p_lo).
  function automatic ksa_gp_t ksa_gp_combine(input ksa_gp_t hi, input ksa_gp_t lo);
    ksa_gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/ksa_pg_cell.sv
// Per-bit generate/propagate cell. Adds the kill output when KSA_PG_KILL_EN is defined.
module ksa_pg_cell (
  input  logic a,
  input  logic b,
`ifdef KSA_PG_KILL_EN
  output logic k,
`endif
  output logic g,
  output logic p
);

  assign g = a & b;
  assign p = a ^ b;
`ifdef KSA_PG_KILL_EN
  assign k = ~(a | b);
`endif

endmodule

// File: rtl/ksa_pg_stage.sv
// Registered level-1 (pre-processing) stage of a Kogge-Stone adder with a
// valid/ready output buffer. Optional kill vector k_ext under KSA_PG_KILL_EN.
module ksa_pg_stage
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef KSA_PG_KILL_EN
  output logic [WIDTH:0]   k_ext,
`endif
  output logic [WIDTH:0]   g_ext,
  output logic [WIDTH:0]   p_ext
);

  logic [WIDTH-1:0] g_bits;
  logic [WIDTH-1:0] p_bits;
  logic [WIDTH:0]   g_nxt;
  logic [WIDTH:0]   p_nxt;
  logic             load;
`ifdef KSA_PG_KILL_EN
  logic [WIDTH-1:0] k_bits;
  logic [WIDTH:0]   k_nxt;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ksa_pg_cell u_cell (
      .a (a[i]),
      .b (b[i]),
`ifdef KSA_PG_KILL_EN
      .k (k_bits[i]),
`endif
      .g (g_bits[i]),
      .p (p_bits[i])
    );
  end

  // Carry-in occupies slot 0 as a generate-only column.
  assign g_nxt = {g_bits, cin};
  assign p_nxt = {p_bits, 1'b0};
`ifdef KSA_PG_KILL_EN
  assign k_nxt = {k_bits, ~cin};
`endif

  // NOTE: in_ready depends only on registered out_valid and the downstream
  // out_ready, so no operand-to-output combinational path exists.
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      g_ext     <= '0;
      p_ext     <= '0;
`ifdef KSA_PG_KILL_EN
      k_ext     <= '0;
`endif
    end else if (load) begin
      out_valid <= 1'b1;
      g_ext     <= g_nxt;
      p_ext     <= p_nxt;
`ifdef KSA_PG_KILL_EN
      k_ext     <= k_nxt;
`endif
    end else if (out_ready) begin
      // Drain with nothing to replace it: data holds, only valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ksa_pg_stage.sv
// Self-checking bench for ksa_pg_stage: scenario tasks plus a scoreboard
// monitor that pops expected vectors on every completed output handshake.
module tb_ksa_pg_stage;

  localparam int W = 32;

  typedef struct packed {
    logic [W:0] g;
    logic [W:0] p;
    logic [W:0] k;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   g_ext;
  logic [W:0]   p_ext;
`ifdef KSA_PG_KILL_EN
  logic [W:0]   k_ext;
`endif

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];

  ksa_pg_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef KSA_PG_KILL_EN
    .k_ext     (k_ext),
`endif
    .g_ext     (g_ext),
    .p_ext     (p_ext)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    exp_t e;
    e.g = {xa & xb, xc};
    e.p = {xa ^ xb, 1'b0};
    e.k = {~(xa | xb), ~xc};
    return e;
  endfunction

  // Scoreboard: sampled mid-cycle when inputs and outputs are both settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: out_valid=1 with no expected beat, g_ext=%h", g_ext);
        end else begin
          e = sb.pop_front();
          if (g_ext !== e.g || p_ext !== e.p) begin
            errors++;
            $display("FAIL sb_beat: got g=%h p=%h, want g=%h p=%h", g_ext, p_ext, e.g, e.p);
          end
`ifdef KSA_PG_KILL_EN
          if (k_ext !== e.k) begin
            errors++;
            $display("FAIL sb_kill: got k=%h, want k=%h", k_ext, e.k);
          end
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, cin));
    end
  end

  task automatic drive(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input logic v, input logic r);
    a         = xa;
    b         = xb;
    cin       = xc;
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic idle_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive('1, '1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || g_ext !== '0 || p_ext !== '0) begin
        errors++;
        $display("FAIL reset_hold: got v=%b g=%h p=%h, want 0 0 0", out_valid, g_ext, p_ext);
      end
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_carry_slot();
    idle_drain();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || g_ext !== 33'h0_0000_0002 || p_ext !== 33'h1_FFFF_FFFC) begin
      errors++;
      $display("FAIL carry_cin0: got v=%b g=%h p=%h, want 1 000000002 1fffffffc",
               out_valid, g_ext, p_ext);
    end
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || g_ext !== 33'h0_0000_0003 || p_ext !== 33'h1_FFFF_FFFC) begin
      errors++;
      $display("FAIL carry_cin1: got v=%b g=%h p=%h, want 1 000000003 1fffffffc",
               out_valid, g_ext, p_ext);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_disjoint();
    idle_drain();
    drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (g_ext !== 33'h0_0000_0000 || p_ext !== 33'h1_FFFF_FFFE) begin
      errors++;
      $display("FAIL disjoint: got g=%h p=%h, want 000000000 1fffffffe", g_ext, p_ext);
    end
`ifdef KSA_PG_KILL_EN
    vectors++;
    if (k_ext !== 33'h0_0000_0001) begin
      errors++;
      $display("FAIL disjoint_kill: got k=%h, want 000000001", k_ext);
    end
`endif
  endtask

  task automatic test_backpressure();
    exp_t ex, ey;
    ex = model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    ey = model(32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b0);
    idle_drain();
    drive(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || g_ext !== ex.g || p_ext !== ex.p) begin
        errors++;
        $display("FAIL stall_hold: got rdy=%b v=%b g=%h p=%h, want 0 1 %h %h",
                 in_ready, out_valid, g_ext, p_ext, ex.g, ex.p);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || g_ext !== ey.g || p_ext !== ey.p) begin
      errors++;
      $display("FAIL stall_replace: got v=%b g=%h p=%h, want 1 %h %h",
               out_valid, g_ext, p_ext, ey.g, ey.p);
    end
  endtask

  task automatic test_hold_on_x();
    exp_t ey;
    ey = model(32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b0);
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || g_ext !== ey.g || p_ext !== ey.p) begin
        errors++;
        $display("FAIL drain_hold: got v=%b g=%h p=%h, want 0 %h %h",
                 out_valid, g_ext, p_ext, ey.g, ey.p);
      end
    end
    drive('0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_streaming();
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rc;
    idle_drain();
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rc);
      drive(ra, rb, rc, 1'b1, 1'b1);
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || g_ext !== e.g || p_ext !== e.p) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b g=%h p=%h, want 1 %h %h",
                 i, out_valid, g_ext, p_ext, e.g, e.p);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    idle_drain();
    drive(32'h0BAD_F00D, 32'h1357_9BDF, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got out_valid=%b, want 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || g_ext !== '0 || p_ext !== '0) begin
      errors++;
      $display("FAIL async_drop: got v=%b g=%h p=%h, want 0 0 0", out_valid, g_ext, p_ext);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_after: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_carry_slot();
    test_disjoint();
    test_backpressure();
    test_hold_on_x();
    test_streaming();
    test_async_reset();
    idle_drain();
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending beats, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ksa_pg_stage.md
Name: ksa_pg_stage

Overview:
- Registered pre-processing (level-1) stage of a Kogge-Stone prefix adder.
- Computes bitwise generate (A&B) and propagate (A^B) for every operand bit.
- Prepends the carry-in as an extra prefix slot: generate = cin, propagate = 0.
- Presents the vectors through one valid/ready pipeline register (the "buffer") that feeds the prefix tree.

Parameters:
- WIDTH, 32, operand width in bits; legal range ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  stage can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  registered beat available.
- out_ready  in  1  downstream accepts the beat.
- g_ext  out  WIDTH+1  registered generate vector; bit 0 = cin, bit i+1 = a[i]&b[i].
- p_ext  out  WIDTH+1  registered propagate vector; bit 0 = 0, bit i+1 = a[i]^b[i].

Behaviour:
- Reset (async assert, any time, including mid-transfer): out_valid=0, g_ext=0, p_ext=0 immediately. No beat survives reset.
- in_ready = !out_valid || out_ready (combinational). No combinational path from a, b or cin to any output.
- Load condition: in_valid && in_ready. On the next edge the register captures the computed vectors and sets out_valid=1.
- Drain without load: out_valid && out_ready && !in_valid clears out_valid on the next edge; data registers hold their last values.
- Simultaneous drain and load: the new beat replaces the old with no bubble, giving full throughput of one beat per cycle.
- Stall: out_valid && !out_ready holds g_ext, p_ext and out_valid stable; in_ready=0.
- Latency: exactly 1 cycle from accepted input to out_valid.
- Arithmetic is purely bitwise; there is no carry arithmetic in this stage.
- p_ext[0] is constant 0 and g_ext[0] is exactly cin, so the prefix tree treats the carry-in as a generate-only column.
- Bit ordering: LSB aligned; p_ext[WIDTH] and g_ext[WIDTH] correspond to a[WIDTH-1] and b[WIDTH-1].
- X on a, b or cin while not loading must not disturb stored outputs.

Optional Feature:
- Macro: KSA_PG_KILL_EN.
- When defined: adds output k_ext (out, WIDTH+1), registered with the same load, hold and reset rules as g_ext and p_ext.
  - k_ext[0] = ~cin.
  - k_ext[i+1] = ~(a[i]|b[i]).
  - Invariant: g, p and k are one-hot per bit.
- When undefined: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Package ksa_pkg:
  - KSA_WIDTH_DEFAULT = 32.
  - Typedef for a {g,p} pair, used by later tree stages.
- One sub-module, ksa_pg_cell: per-bit combinational cell.
  - Inputs a, b.
  - Outputs g = a&b, p = a^b, and k = ~(a|b) when KSA_PG_KILL_EN is defined.
  - Instantiated WIDTH times inside a generate loop.
- Handshake register logic stays in ksa_pg_stage.

Test Plan:
- Reset while holding a=0xFFFFFFFF, b=0xFFFFFFFF, in_valid=1 → out_valid=0, g_ext=0, p_ext=0 throughout reset. in_ready=1 after release.
- Carry-in slot: a=0xFFFFFFFF, b=0x00000001, cin=0 → after 1 cycle g_ext=0x000000002, p_ext=0x1FFFFFFFC. Same operands with cin=1 → g_ext=0x000000003, p_ext unchanged.
- Disjoint operands: a=0xAAAAAAAA, b=0x55555555, cin=0 → g_ext=0x000000000, p_ext=0x1FFFFFFFE. With KSA_PG_KILL_EN: k_ext=0x000000001.
- Backpressure: load beat X, hold out_ready=0 for 3 cycles while presenting beat Y → in_ready=0 and outputs stay X. Raise out_ready → Y appears the cycle after X is consumed.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with random a, b, cin → one result per cycle, each matching the bitwise model delayed by 1, with no bubbles.
- Async reset asserted between edges while out_valid=1 → out_valid drops before the next clock edge.
